// File: rtl/vend_pkg.sv
// Shared types and constants for the vending credit controller.
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CREDIT,
        DISPENSE,
        REFUND
    } vend_state_t;

    localparam int unsigned COIN5  = 5;
    localparam int unsigned COIN10 = 10;
    localparam int unsigned COIN25 = 25;

    typedef logic [3:0] bcd_t;

    // Double-dabble correction: a digit of 5 or more would overflow on the next shift.
    function automatic bcd_t dabble_adj(input bcd_t d);
        return (d >= 4'd5) ? bcd_t'(d + 4'd3) : d;
    endfunction

endpackage

// File: rtl/bin2bcd.sv
// Free-running sequential double-dabble converter: sample, W shift steps, then load digits.
module bin2bcd
    import vend_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] bin,
    output bcd_t         hund,
    output bcd_t         tens,
    output bcd_t         ones,
    output logic         done
);

    localparam int unsigned CW = $clog2(W + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  sr_q, sr_d;
    logic [11:0]   acc_q, acc_d;
    logic [11:0]   acc_adj;
    bcd_t          hund_q, hund_d, tens_q, tens_d, ones_q, ones_d;
    logic          done_q, done_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            sr_q   <= '0;
            acc_q  <= '0;
            hund_q <= '0;
            tens_q <= '0;
            ones_q <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sr_q   <= sr_d;
            acc_q  <= acc_d;
            hund_q <= hund_d;
            tens_q <= tens_d;
            ones_q <= ones_d;
            done_q <= done_d;
        end
    end

    always_comb begin
        acc_adj = {dabble_adj(acc_q[11:8]), dabble_adj(acc_q[7:4]), dabble_adj(acc_q[3:0])};
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        acc_d   = acc_q;
        hund_d  = hund_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        done_d  = 1'b0;
        // Count 0 both publishes the finished conversion and samples the next input.
        if (cnt_q == '0) begin
            hund_d = acc_q[11:8];
            tens_d = acc_q[7:4];
            ones_d = acc_q[3:0];
            done_d = 1'b1;
            sr_d   = bin;
            acc_d  = '0;
            cnt_d  = CW'(1);
        end else begin
            {acc_d, sr_d} = {acc_adj, sr_q} << 1;
            cnt_d = (cnt_q == CW'(W)) ? '0 : cnt_q + CW'(1);
        end
    end

    assign hund = hund_q;
    assign tens = tens_q;
    assign ones = ones_q;
    assign done = done_q;

endmodule

// File: rtl/vend_credit.sv
// Coin-credit controller: accumulates coins, vends, refunds in 5p pulses, and drives BCD credit digits.
module vend_credit
    import vend_pkg::*;
#(
    parameter int unsigned PRICE      = 75,
    parameter int unsigned MAX_CREDIT = 195
) (
    input  logic clk,
    input  logic reset,
    input  logic coin_5,
    input  logic coin_10,
    input  logic coin_25,
    input  logic vend_req,
    input  logic cancel,
    output logic dispense,
    output logic change_5,
    output logic coin_reject,
    output logic short_credit,
    output bcd_t digit_hund,
    output bcd_t digit_tens,
    output bcd_t digit_ones,
    output logic busy
);

    vend_state_t state_q, state_d;
    logic [7:0]  credit_q, credit_d;
    logic        dispense_q, dispense_d, change_5_q, change_5_d;
    logic        coin_reject_q, coin_reject_d, short_credit_q, short_credit_d;
    logic        busy_q, busy_d;
    logic        any_coin, one_coin, coin_accept, accepting;
    logic [7:0]  coin_val;
    logic [8:0]  credit_sum;
    logic        bcd_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            credit_q       <= '0;
            dispense_q     <= 1'b0;
            change_5_q     <= 1'b0;
            coin_reject_q  <= 1'b0;
            short_credit_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            dispense_q     <= dispense_d;
            change_5_q     <= change_5_d;
            coin_reject_q  <= coin_reject_d;
            short_credit_q <= short_credit_d;
            busy_q         <= busy_d;
        end
    end

    always_comb begin
        any_coin   = coin_5 | coin_10 | coin_25;
        one_coin   = ($countones({coin_25, coin_10, coin_5}) == 1);
        coin_val   = coin_25 ? 8'(COIN25) : (coin_10 ? 8'(COIN10) : 8'(COIN5));
        credit_sum = {1'b0, credit_q} + {1'b0, coin_val};
        accepting  = (state_q == IDLE) || (state_q == CREDIT);
    end

    always_comb begin
        state_d     = state_q;
        credit_d    = credit_q;
        coin_accept = 1'b0;
        unique case (state_q)
            IDLE, CREDIT: begin
                if (cancel && state_q == CREDIT) begin
                    state_d = REFUND;
                end else if (vend_req) begin
                    if (state_q == CREDIT && credit_q >= 8'(PRICE)) begin
                        state_d  = DISPENSE;
                        credit_d = credit_q - 8'(PRICE);
                    end
                end else if (!cancel && one_coin && credit_sum <= 9'(MAX_CREDIT)) begin
                    state_d     = CREDIT;
                    credit_d    = credit_sum[7:0];
                    coin_accept = 1'b1;
                end
            end
            DISPENSE: state_d = (credit_q != '0) ? REFUND : IDLE;
            REFUND: begin
                credit_d = credit_q - 8'(COIN5);
                if (credit_q == 8'(COIN5)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Pulses are decoded from the next state so they line up with the state they describe.
    always_comb begin
        dispense_d     = (state_d == DISPENSE);
        change_5_d     = (state_d == REFUND);
        busy_d         = (state_d == DISPENSE) || (state_d == REFUND);
        coin_reject_d  = any_coin && !coin_accept;
        short_credit_d = accepting && vend_req && !(cancel && state_q == CREDIT)
                         && ((state_q == IDLE) || (credit_q < 8'(PRICE)));
    end

    bin2bcd #(.W(8)) u_bin2bcd (
        .clk   (clk),
        .reset (reset),
        .bin   (credit_q),
        .hund  (digit_hund),
        .tens  (digit_tens),
        .ones  (digit_ones),
        .done  (bcd_done)
    );

    assign dispense     = dispense_q;
    assign change_5     = change_5_q;
    assign coin_reject  = coin_reject_q;
    assign short_credit = short_credit_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_vend_credit.sv
// Directed scenario bench for vend_credit.
module tb_vend_credit;
    import vend_pkg::*;

    logic clk = 1'b0;
    logic reset, coin_5, coin_10, coin_25, vend_req, cancel;
    logic dispense, change_5, coin_reject, short_credit, busy;
    bcd_t digit_hund, digit_tens, digit_ones;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    vend_credit #(.PRICE(75), .MAX_CREDIT(195)) dut (
        .clk          (clk),
        .reset        (reset),
        .coin_5       (coin_5),
        .coin_10      (coin_10),
        .coin_25      (coin_25),
        .vend_req     (vend_req),
        .cancel       (cancel),
        .dispense     (dispense),
        .change_5     (change_5),
        .coin_reject  (coin_reject),
        .short_credit (short_credit),
        .digit_hund   (digit_hund),
        .digit_tens   (digit_tens),
        .digit_ones   (digit_ones),
        .busy         (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic drive(input logic c5, input logic c10, input logic c25,
                         input logic v, input logic c);
        coin_5 = c5; coin_10 = c10; coin_25 = c25; vend_req = v; cancel = c;
        tick();
        coin_5 = 0; coin_10 = 0; coin_25 = 0; vend_req = 0; cancel = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ticks(2);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({dispense, change_5, coin_reject, short_credit, busy} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_pulses: got %b expected 00000",
                     {dispense, change_5, coin_reject, short_credit, busy});
        end
        n_checks++;
        if (dut.credit_q !== 8'd0 || dut.state_q !== IDLE) begin
            n_fail++;
            $display("FAIL reset_state: credit %0d state %0d expected 0 IDLE", dut.credit_q, dut.state_q);
        end
        n_checks++;
        if ({digit_hund, digit_tens, digit_ones} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_digits: got %h expected 000", {digit_hund, digit_tens, digit_ones});
        end
    endtask

    task automatic test_exact_vend();
        int chg = 0;
        do_reset();
        for (int i = 0; i < 3; i++) drive(0, 0, 1, 0, 0);
        n_checks++;
        if (dut.credit_q !== 8'd75 || dut.state_q !== CREDIT) begin
            n_fail++;
            $display("FAIL exact_credit: credit %0d state %0d expected 75 CREDIT", dut.credit_q, dut.state_q);
        end
        drive(0, 0, 0, 1, 0);
        n_checks++;
        if (dispense !== 1'b1 || busy !== 1'b1 || dut.credit_q !== 8'd0) begin
            n_fail++;
            $display("FAIL exact_dispense: disp %b busy %b credit %0d expected 1 1 0", dispense, busy, dut.credit_q);
        end
        tick();
        n_checks++;
        if (dispense !== 1'b0 || dut.state_q !== IDLE || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL exact_idle: disp %b state %0d busy %b expected 0 IDLE 0", dispense, dut.state_q, busy);
        end
        for (int i = 0; i < 18; i++) begin
            if (change_5 === 1'b1) chg++;
            tick();
        end
        n_checks++;
        if (chg !== 0) begin
            n_fail++;
            $display("FAIL exact_no_change: got %0d change pulses expected 0", chg);
        end
        n_checks++;
        if ({digit_hund, digit_tens, digit_ones} !== 12'h000) begin
            n_fail++;
            $display("FAIL exact_digits: got %h expected 000", {digit_hund, digit_tens, digit_ones});
        end
    endtask

    task automatic test_refund_100();
        int busy_cnt = 0, chg = 0, disp = 0, first = -1, last = -1;
        do_reset();
        for (int i = 0; i < 4; i++) drive(0, 0, 1, 0, 0);
        drive(0, 0, 0, 1, 0);
        for (int i = 0; i < 12; i++) begin
            if (busy === 1'b1) busy_cnt++;
            if (dispense === 1'b1) disp++;
            if (change_5 === 1'b1) begin
                chg++;
                if (first < 0) first = i;
                last = i;
            end
            tick();
        end
        n_checks++;
        if (disp !== 1 || chg !== 5) begin
            n_fail++;
            $display("FAIL refund_counts: dispense %0d change %0d expected 1 5", disp, chg);
        end
        n_checks++;
        if (first !== 1 || last !== 5) begin
            n_fail++;
            $display("FAIL refund_consecutive: first %0d last %0d expected 1 5", first, last);
        end
        n_checks++;
        if (busy_cnt !== 6) begin
            n_fail++;
            $display("FAIL refund_busy: got %0d cycles expected 6", busy_cnt);
        end
        n_checks++;
        if (dut.credit_q !== 8'd0 || dut.state_q !== IDLE) begin
            n_fail++;
            $display("FAIL refund_final: credit %0d state %0d expected 0 IDLE", dut.credit_q, dut.state_q);
        end
    endtask

    task automatic test_short_credit();
        do_reset();
        drive(0, 0, 0, 1, 0);
        n_checks++;
        if (short_credit !== 1'b1 || dut.state_q !== IDLE) begin
            n_fail++;
            $display("FAIL short_idle: short %b state %0d expected 1 IDLE", short_credit, dut.state_q);
        end
        drive(0, 1, 0, 0, 0);
        drive(0, 0, 0, 1, 0);
        n_checks++;
        if (short_credit !== 1'b1 || dut.credit_q !== 8'd10 || dut.state_q !== CREDIT || dispense !== 1'b0) begin
            n_fail++;
            $display("FAIL short_credit: short %b credit %0d state %0d disp %b expected 1 10 CREDIT 0",
                     short_credit, dut.credit_q, dut.state_q, dispense);
        end
        tick();
        n_checks++;
        if (short_credit !== 1'b0) begin
            n_fail++;
            $display("FAIL short_width: got %b expected 0", short_credit);
        end
        ticks(17);
        n_checks++;
        if ({digit_hund, digit_tens, digit_ones} !== 12'h010) begin
            n_fail++;
            $display("FAIL short_digits: got %h expected 010", {digit_hund, digit_tens, digit_ones});
        end
    endtask

    task automatic test_ceiling();
        do_reset();
        for (int i = 0; i < 7; i++) drive(0, 0, 1, 0, 0);
        drive(0, 1, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        n_checks++;
        if (dut.credit_q !== 8'd190) begin
            n_fail++;
            $display("FAIL ceil_build: credit %0d expected 190", dut.credit_q);
        end
        drive(0, 1, 0, 0, 0);
        n_checks++;
        if (coin_reject !== 1'b1 || dut.credit_q !== 8'd190) begin
            n_fail++;
            $display("FAIL ceil_reject: reject %b credit %0d expected 1 190", coin_reject, dut.credit_q);
        end
        drive(1, 0, 0, 0, 0);
        n_checks++;
        if (coin_reject !== 1'b0 || dut.credit_q !== 8'd195) begin
            n_fail++;
            $display("FAIL ceil_accept: reject %b credit %0d expected 0 195", coin_reject, dut.credit_q);
        end
        ticks(17);
        n_checks++;
        if ({digit_hund, digit_tens, digit_ones} !== 12'h195) begin
            n_fail++;
            $display("FAIL ceil_digits: got %h expected 195", {digit_hund, digit_tens, digit_ones});
        end
    endtask

    task automatic test_multi_coin();
        int chg = 0;
        do_reset();
        drive(0, 1, 0, 0, 0);
        drive(1, 1, 0, 0, 0);
        n_checks++;
        if (coin_reject !== 1'b1 || dut.credit_q !== 8'd10) begin
            n_fail++;
            $display("FAIL multi_reject: reject %b credit %0d expected 1 10", coin_reject, dut.credit_q);
        end
        drive(0, 1, 0, 0, 0);
        drive(0, 0, 1, 0, 1);
        n_checks++;
        if (coin_reject !== 1'b1 || dut.state_q !== REFUND || dut.credit_q !== 8'd20) begin
            n_fail++;
            $display("FAIL cancel_wins: reject %b state %0d credit %0d expected 1 REFUND 20",
                     coin_reject, dut.state_q, dut.credit_q);
        end
        for (int i = 0; i < 8; i++) begin
            if (change_5 === 1'b1) chg++;
            tick();
        end
        n_checks++;
        if (chg !== 4 || dut.credit_q !== 8'd0 || dut.state_q !== IDLE) begin
            n_fail++;
            $display("FAIL cancel_refund: change %0d credit %0d state %0d expected 4 0 IDLE",
                     chg, dut.credit_q, dut.state_q);
        end
    endtask

    task automatic test_reset_mid_refund();
        int chg = 0;
        do_reset();
        drive(0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 1);
        ticks(2);
        n_checks++;
        if (change_5 !== 1'b1 || dut.credit_q !== 8'd15) begin
            n_fail++;
            $display("FAIL midref_third: change %b credit %0d expected 1 15", change_5, dut.credit_q);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if (change_5 !== 1'b0 || busy !== 1'b0 || dut.credit_q !== 8'd0 || dut.state_q !== IDLE) begin
            n_fail++;
            $display("FAIL midref_reset: change %b busy %b credit %0d state %0d expected 0 0 0 IDLE",
                     change_5, busy, dut.credit_q, dut.state_q);
        end
        n_checks++;
        if ({digit_hund, digit_tens, digit_ones} !== 12'h000) begin
            n_fail++;
            $display("FAIL midref_digits: got %h expected 000", {digit_hund, digit_tens, digit_ones});
        end
        for (int i = 0; i < 6; i++) begin
            if (change_5 === 1'b1) chg++;
            tick();
        end
        n_checks++;
        if (chg !== 0) begin
            n_fail++;
            $display("FAIL midref_quiet: got %0d change pulses expected 0", chg);
        end
    endtask

    initial begin
        reset = 1'b1; coin_5 = 0; coin_10 = 0; coin_25 = 0; vend_req = 0; cancel = 0;
        test_reset();
        test_exact_vend();
        test_refund_100();
        test_short_credit();
        test_ceiling();
        test_multi_coin();
        test_reset_mid_refund();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vend_credit.md
Name: vend_credit

Overview:
- Coin-credit controller for the vending machine; sits directly upstream of the hex-to-seven-segment decoders.
- Accumulates inserted coin value, handles vend and cancel requests, and pays out refunds as 5p change pulses.
- Continuously converts the binary credit to three BCD digits; each digit drives one seven-segment decoder instance.

Parameters:
- PRICE, 75: item price in pence. Must be a multiple of 5 and ≤ MAX_CREDIT.
- MAX_CREDIT, 195: credit ceiling in pence. Must be a multiple of 5 and ≤ 255.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- coin_5  in  1  one-cycle pulse, already synchronised: 5p coin accepted by the mechanism
- coin_10  in  1  one-cycle pulse: 10p coin
- coin_25  in  1  one-cycle pulse: 25p coin
- vend_req  in  1  one-cycle pulse: vend button pressed
- cancel  in  1  one-cycle pulse: refund button pressed
- dispense  out  1  one-cycle pulse: release item
- change_5  out  1  one-cycle pulse: eject one 5p coin
- coin_reject  out  1  one-cycle pulse: return the coin just inserted
- short_credit  out  1  one-cycle pulse: vend refused, credit < PRICE
- digit_hund  out  4  BCD hundreds digit of credit
- digit_tens  out  4  BCD tens digit of credit
- digit_ones  out  4  BCD ones digit of credit
- busy  out  1  high while in DISPENSE or REFUND

Behaviour:
- Reset values: credit = 0, state IDLE, all pulse outputs 0, all digits 0, busy 0, BCD converter restarts.
- Internal credit register: 8-bit binary, always a multiple of 5.
- All outputs are registered. Each pulse asserts in the cycle after its cause and lasts exactly one cycle.
- States: IDLE (credit = 0), CREDIT (credit > 0), DISPENSE, REFUND.
- Coin handling (IDLE or CREDIT):
  - Exactly one coin pulse: if credit + value ≤ MAX_CREDIT, add it and move to CREDIT.
  - Otherwise: coin_reject, credit unchanged.
  - Two or more coin pulses in the same cycle: coin_reject, no credit added.
- Coins arriving in DISPENSE or REFUND, or in the same cycle as vend_req or cancel: coin_reject, no credit added.
- Same-cycle priority: cancel > vend_req > coin.
- cancel:
  - In CREDIT: go to REFUND.
  - In IDLE, DISPENSE or REFUND: ignored.
- vend_req:
  - In CREDIT with credit ≥ PRICE: go to DISPENSE and set credit = credit − PRICE.
  - In CREDIT with credit < PRICE: short_credit, state unchanged.
  - In IDLE: short_credit.
  - In DISPENSE or REFUND: ignored.
- DISPENSE: lasts exactly one cycle and asserts dispense. Then goes to REFUND if credit > 0, else IDLE. Leftover credit is always refunded.
- REFUND: each cycle asserts change_5 and sets credit −= 5. When credit reaches 0 in that cycle, go to IDLE. Refund of N pence = N/5 consecutive change_5 pulses.
- busy = state is DISPENSE or REFUND.
- Display path:
  - Free-running bin2bcd converter: samples credit, runs 8 shift iterations, then loads the digit registers.
  - Sample-to-digit latency is 9 cycles; conversion restarts immediately after each load.
  - Digits change only on load, so no intermediate values appear. Stale values are tolerated for at most 18 cycles.
- reset asserted mid-refund or mid-conversion: everything returns to reset values on the next edge. Credit is lost by design.

Decomposition:
- Package vend_pkg holds:
  - state enum vend_state_t {IDLE, CREDIT, DISPENSE, REFUND};
  - coin value constants COIN5 = 5, COIN10 = 10, COIN25 = 25;
  - BCD digit typedef bcd_t = logic [3:0].
- One sub-module: bin2bcd.
  - Sequential double-dabble with a parameterised input width (8 here).
  - Ports: clk, reset, bin in, three bcd_t out, done pulse.

Test Plan:
- Reset, then coin_25 ×3 and vend_req: credit 75; dispense pulses once; no change_5 pulses; state returns to IDLE; digits settle to 0,0,0.
- coin_25 ×4 (100) and vend_req: dispense, then exactly 5 change_5 pulses on consecutive cycles; busy high for 6 cycles; final credit 0.
- coin_10, then vend_req: short_credit pulses; credit stays 10; digits read 0,1,0 within 18 cycles.
- Credit at 190, then coin_10: coin_reject pulses, credit stays 190. Then coin_5: credit 195, digits read 1,9,5.
- coin_5 and coin_10 asserted in the same cycle: coin_reject, credit unchanged. coin_25 asserted with cancel at credit 20: cancel wins, coin_reject pulses, 4 change_5 pulses follow.
- reset asserted during the 3rd change_5 of a refund: the next cycle shows credit 0, IDLE, no further pulses, and digits 0,0,0.
